// File: rtl/cpu_test_ctrl_if.sv
// Writeback and golden-trace channel between the test harness and cpu_test_ctrl.
// master: the side that drives the commit and golden streams; slave: the controller.
interface cpu_test_ctrl_if #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
);
  logic              wb_valid;
  logic [PC_W-1:0]   wb_pc;
  logic [REG_AW-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              gold_valid;
  logic [PC_W-1:0]   gold_pc;
  logic [REG_AW-1:0] gold_reg;
  logic [DATA_W-1:0] gold_data;
  logic              gold_last;
  logic              gold_pop;

  modport master (
    output wb_valid, wb_pc, wb_reg, wb_data,
    output gold_valid, gold_pc, gold_reg, gold_data, gold_last,
    input  gold_pop
  );

  modport slave (
    input  wb_valid, wb_pc, wb_reg, wb_data,
    input  gold_valid, gold_pc, gold_reg, gold_data, gold_last,
    output gold_pop
  );
endinterface

// File: rtl/cpu_test_ctrl.sv
// Test harness controller: sequences the CPU reset, compares each writeback against
// a show-ahead golden trace, and reports pass/fail/timeout with counters.
module cpu_test_ctrl #(
  parameter int unsigned RESET_CYCLES   = 200,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_ERRS       = 16,
  parameter int unsigned PC_W           = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned REG_AW         = 5,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned IGNORE_R0      = 1
) (
  input  logic             clk,
  input  logic             reset,
  cpu_test_ctrl_if.slave   bus,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [7:0]       err_cnt,
  output logic [CNT_W-1:0] wb_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [PC_W-1:0]  first_err_pc
);

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_DONE} state_t;

  localparam logic [31:0]      HOLD_LAST = 32'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       MAX_E     = 8'(MAX_ERRS);

  state_t           r_state, w_next;
  logic [31:0]      r_hold_cnt;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_wb_cnt;
  logic [7:0]       r_err_cnt;
  logic [PC_W-1:0]  r_first_err_pc;
  logic             r_pass;
  logic             r_timeout;

  logic       w_run, w_elig, w_pop, w_mism, w_err, w_last, w_abort, w_tmo;
  logic       w_set_pass, w_set_tmo;
  logic [7:0] w_err_nxt;

  assign w_run   = (r_state == S_RUN);
  assign w_elig  = bus.wb_valid && !((IGNORE_R0 != 0) && (bus.wb_reg == '0));
  assign w_pop   = w_run && w_elig && bus.gold_valid;
  assign w_mism  = (bus.wb_pc != bus.gold_pc) || (bus.wb_reg != bus.gold_reg) ||
                   (bus.wb_data != bus.gold_data);
  assign w_err   = w_run && w_elig && (!bus.gold_valid || w_mism);
  assign w_err_nxt = (w_err && (r_err_cnt < MAX_E)) ? r_err_cnt + 8'd1 : r_err_cnt;
  assign w_last  = w_pop && bus.gold_last;
  assign w_abort = w_err && (w_err_nxt >= MAX_E);
  assign w_tmo   = (r_cycle_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_HOLD;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_set_pass = 1'b0;
    w_set_tmo  = 1'b0;
    case (r_state)
      S_HOLD: if (r_hold_cnt == HOLD_LAST) w_next = S_RUN;
      S_RUN: begin
        // Completion outranks both the error abort and a coincident timeout.
        if (w_last) begin
          w_next     = S_DONE;
          w_set_pass = (r_err_cnt == '0) && !w_err;
        end else if (w_abort) begin
          w_next = S_DONE;
        end else if (w_tmo) begin
          w_next    = S_DONE;
          w_set_tmo = 1'b1;
        end
      end
      S_DONE:  w_next = S_DONE;
      default: w_next = S_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_cnt     <= '0;
      r_cycle_cnt    <= '0;
      r_wb_cnt       <= '0;
      r_err_cnt      <= '0;
      r_first_err_pc <= '0;
      r_pass         <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      if (r_state == S_HOLD) r_hold_cnt <= r_hold_cnt + 32'd1;
      if (w_run) begin
        // The exiting cycle is not added, so a timeout leaves cycle_cnt at TIMEOUT_CYCLES-1.
        if (w_next == S_RUN) r_cycle_cnt <= r_cycle_cnt + 1'b1;
        if (w_pop) r_wb_cnt <= r_wb_cnt + 1'b1;
        r_err_cnt <= w_err_nxt;
        if (w_err && (r_err_cnt == '0)) r_first_err_pc <= bus.wb_pc;
        if (w_next == S_DONE) begin
          r_pass    <= w_set_pass;
          r_timeout <= w_set_tmo;
        end
      end
    end
  end

  assign bus.gold_pop  = !reset && w_pop;
  assign cpu_reset     = reset || (r_state != S_RUN);
  assign busy          = reset || (r_state != S_DONE);
  assign done          = !reset && (r_state == S_DONE);
  assign pass          = !reset && r_pass;
  assign timeout       = !reset && r_timeout;
  assign err_cnt       = reset ? '0 : r_err_cnt;
  assign wb_cnt        = reset ? '0 : r_wb_cnt;
  assign cycle_cnt     = reset ? '0 : r_cycle_cnt;
  assign first_err_pc  = reset ? '0 : r_first_err_pc;

endmodule

// File: tb/tb_cpu_test_ctrl.sv
// Directed bench for cpu_test_ctrl: vector table of per-cycle commits plus
// hand-written reset/hold, mid-run reset and timeout sequences.
module tb_cpu_test_ctrl;
  localparam int unsigned RC  = 4;
  localparam int unsigned TO  = 50;
  localparam int unsigned MXE = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_reset, busy, done, pass, timeout;
  logic [7:0]  err_cnt;
  logic [31:0] wb_cnt, cycle_cnt, first_err_pc;

  int n_chk = 0;
  int n_err = 0;

  cpu_test_ctrl_if #(.PC_W(32), .DATA_W(32), .REG_AW(5)) bus ();

  cpu_test_ctrl #(
    .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO), .MAX_ERRS(MXE),
    .PC_W(32), .DATA_W(32), .REG_AW(5), .CNT_W(32), .IGNORE_R0(1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_cnt(err_cnt), .wb_cnt(wb_cnt),
    .cycle_cnt(cycle_cnt), .first_err_pc(first_err_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic        wv;
    logic [31:0] wpc;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        gv;
    logic [31:0] gpc;
    logic [4:0]  gr;
    logic [31:0] gd;
    logic        gl;
    logic        pop;
    logic [7:0]  err;
    logic [31:0] wbc;
    logic        dn;
    logic        ps;
    logic [31:0] fepc;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [31:0] wpc, input logic [4:0] wr,
                       input logic [31:0] wd, input logic gv, input logic [31:0] gpc,
                       input logic [4:0] gr, input logic [31:0] gd, input logic gl);
    bus.wb_valid = wv; bus.wb_pc = wpc; bus.wb_reg = wr; bus.wb_data = wd;
    bus.gold_valid = gv; bus.gold_pc = gpc; bus.gold_reg = gr; bus.gold_data = gd;
    bus.gold_last = gl;
  endtask

  // Reset for one edge, check the reset state, then check the HOLD window.
  task automatic do_reset();
    reset = 1'b1;
    drive(1'b1, 32'h4, 5'd1, 32'd11, 1'b1, 32'h4, 5'd1, 32'd11, 1'b0);
    @(negedge clk);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_wb_cnt", wb_cnt, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_first_err_pc", first_err_pc, 0);
    chk("rst_gold_pop", bus.gold_pop, 0);
    reset = 1'b0;
    for (int unsigned i = 0; i < RC; i++) begin
      #1;
      chk("hold_cpu_reset", cpu_reset, 1);
      chk("hold_busy", busy, 1);
      chk("hold_gold_pop", bus.gold_pop, 0);
      chk("hold_cycle_cnt", cycle_cnt, 0);
      @(negedge clk);
    end
    chk("run_cpu_reset", cpu_reset, 0);
    chk("run_busy", busy, 1);
  endtask

  task automatic apply(input int idx);
    vec_t v;
    v = tbl[idx];
    drive(v.wv, v.wpc, v.wr, v.wd, v.gv, v.gpc, v.gr, v.gd, v.gl);
    #1;
    chk($sformatf("v%0d_gold_pop", idx), bus.gold_pop, v.pop);
    @(negedge clk);
    chk($sformatf("v%0d_err_cnt", idx), err_cnt, v.err);
    chk($sformatf("v%0d_wb_cnt", idx), wb_cnt, v.wbc);
    chk($sformatf("v%0d_done", idx), done, v.dn);
    chk($sformatf("v%0d_pass", idx), pass, v.ps);
    chk($sformatf("v%0d_timeout", idx), timeout, 0);
    chk($sformatf("v%0d_first_err_pc", idx), first_err_pc, v.fepc);
    chk($sformatf("v%0d_cpu_reset", idx), cpu_reset, v.dn);
    chk($sformatf("v%0d_busy", idx), busy, !v.dn);
  endtask

  initial begin
    int n;
    //          rst wv  wpc    wr  wd      gv  gpc    gr  gd     gl   pop err wbc dn ps fepc
    // three-entry trace, all matching; then a commit while DONE
    tbl[0]  = '{1, 0, 32'h0,  0, 32'd0,  1, 32'h4,  1, 32'd11, 0,  0, 0, 0, 0, 0, 32'h0};
    tbl[1]  = '{0, 1, 32'h4,  1, 32'd11, 1, 32'h4,  1, 32'd11, 0,  1, 0, 1, 0, 0, 32'h0};
    tbl[2]  = '{0, 1, 32'h8,  2, 32'd22, 1, 32'h8,  2, 32'd22, 0,  1, 0, 2, 0, 0, 32'h0};
    tbl[3]  = '{0, 1, 32'hC,  3, 32'd33, 1, 32'hC,  3, 32'd33, 1,  1, 0, 3, 1, 1, 32'h0};
    tbl[4]  = '{0, 1, 32'h10, 4, 32'd44, 1, 32'h10, 4, 32'd44, 1,  0, 0, 3, 1, 1, 32'h0};
    // entry 2 data off by one at pc 8
    tbl[5]  = '{1, 1, 32'h4,  1, 32'd11, 1, 32'h4,  1, 32'd11, 0,  1, 0, 1, 0, 0, 32'h0};
    tbl[6]  = '{0, 1, 32'h8,  2, 32'd23, 1, 32'h8,  2, 32'd22, 0,  1, 1, 2, 0, 0, 32'h8};
    tbl[7]  = '{0, 1, 32'hC,  3, 32'd33, 1, 32'hC,  3, 32'd33, 1,  1, 1, 3, 1, 0, 32'h8};
    // reg-0 writes ignored, extra commit with no golden entry
    tbl[8]  = '{1, 1, 32'h4,  0, 32'd5,  0, 32'h0,  0, 32'd0,  0,  0, 0, 0, 0, 0, 32'h0};
    tbl[9]  = '{0, 1, 32'h10, 4, 32'd7,  0, 32'h0,  0, 32'd0,  0,  0, 1, 0, 0, 0, 32'h10};
    tbl[10] = '{0, 1, 32'h14, 0, 32'd9,  1, 32'h14, 5, 32'd9,  0,  0, 1, 0, 0, 0, 32'h10};
    // error count reaches MAX_ERRS=3 and aborts; DONE then ignores commits
    tbl[11] = '{1, 1, 32'h20, 1, 32'd1,  0, 32'h0,  0, 32'd0,  0,  0, 1, 0, 0, 0, 32'h20};
    tbl[12] = '{0, 1, 32'h24, 1, 32'd2,  1, 32'h24, 2, 32'd2,  0,  1, 2, 1, 0, 0, 32'h20};
    tbl[13] = '{0, 1, 32'h28, 3, 32'd3,  0, 32'h0,  0, 32'd0,  0,  0, 3, 1, 1, 0, 32'h20};
    tbl[14] = '{0, 1, 32'h2C, 3, 32'd3,  0, 32'h0,  0, 32'd0,  0,  0, 3, 1, 1, 0, 32'h20};
    // two compares before a mid-run reset
    tbl[15] = '{1, 1, 32'h4,  1, 32'd11, 1, 32'h4,  1, 32'd11, 0,  1, 0, 1, 0, 0, 32'h0};
    tbl[16] = '{0, 1, 32'h8,  2, 32'd22, 1, 32'h8,  2, 32'd22, 0,  1, 0, 2, 0, 0, 32'h0};

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].rst) do_reset();
      apply(i);
    end

    // mid-run reset after two compares, then a clean rerun
    do_reset();
    for (int i = 1; i <= 3; i++) apply(i);

    // CPU never commits: timeout after TO RUN cycles
    do_reset();
    drive(0, 0, 0, 0, 1, 32'h4, 5'd1, 32'd11, 0);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_run_cycles", n, TO);
    chk("tmo_done", done, 1);
    chk("tmo_timeout", timeout, 1);
    chk("tmo_pass", pass, 0);
    chk("tmo_cycle_cnt", cycle_cnt, TO - 1);
    chk("tmo_err_cnt", err_cnt, 0);
    chk("tmo_cpu_reset", cpu_reset, 1);
    repeat (3) @(negedge clk);
    chk("tmo_cycle_cnt_frozen", cycle_cnt, TO - 1);
    chk("tmo_done_sticky", done, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
